// File: rtl/lsuc_pkg.sv
// lsuc_pkg: shared definitions for lsuc local-IO-bus responders.
//   - Timer register offsets (full 8-bit offsets, so any addr[7:3] != 0
//     never matches a mapped register).
//   - CTRL register bit positions.
//   - Bus responder FSM state encoding, reusable by other responders.
package lsuc_pkg;

  localparam logic [7:0] TMR_CTRL      = 8'h00;
  localparam logic [7:0] TMR_STATUS    = 8'h01;
  localparam logic [7:0] TMR_RELOAD_LO = 8'h02;
  localparam logic [7:0] TMR_RELOAD_HI = 8'h03;
  localparam logic [7:0] TMR_COUNT_LO  = 8'h04;
  localparam logic [7:0] TMR_COUNT_HI  = 8'h05;
  localparam logic [7:0] TMR_PRESCALE  = 8'h06;

  localparam int CTRL_EN_BIT          = 0;
  localparam int CTRL_AUTO_RELOAD_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT      = 2;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_WAIT = 2'd1,
    BUS_ACK  = 2'd2
  } bus_state_e;

endpackage

// File: rtl/lsuc_prescaler.sv
// lsuc_prescaler: 8-bit clock divider producing a one-cycle tick every
// div+1 clocks while enabled.
//   clk   in   clock
//   reset in   synchronous active-high reset
//   en    in   run enable; the divider is held at 0 while low
//   clr   in   restart the divide period
//   div   in   divide value (tick period = div+1)
//   tick  out  one-cycle pulse when the divider wraps
module lsuc_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] cnt;

  assign tick = en && (cnt == div);

  // Holding at 0 while disabled makes the first tick land div+1 cycles
  // after enable.
  always_ff @(posedge clk) begin
    if (reset || clr || !en) begin
      cnt <= 8'd0;
    end else if (cnt == div) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/lsuc_timer.sv
// lsuc_timer: programmable 16-bit down-counter responder on the lsuc
// local IO bus, with prescaled tick, one-shot/auto-reload expiry and a
// level interrupt.
//   WAIT_STATES  idle cycles between request capture and rdy (0..15)
//   clk          clock
//   reset        synchronous active-high reset
//   addr         register offset
//   rnw          1 = read, 0 = write
//   req          single-cycle request strobe
//   wr_data      write data
//   cs           chip select
//   rd_data      read data, valid with rdy, held until the next access
//   rdy          one-cycle completion pulse
//   irq          registered expired & irq_en
//
// Bus FSM states:
//   state    | meaning
//   BUS_IDLE | waiting for req && cs; access is captured and executed here
//   BUS_WAIT | counting down wait states
//   BUS_ACK  | rdy high for one cycle with rd_data
module lsuc_timer
  import lsuc_pkg::*;
#(
  parameter logic [3:0] WAIT_STATES = 4'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic       rnw,
  input  logic       req,
  input  logic [7:0] wr_data,
  input  logic       cs,
  output logic [7:0] rd_data,
  output logic       rdy,
  output logic       irq
);

  bus_state_e state;
  logic [3:0] wait_cnt;
  logic [7:0] rd_hold;
  logic [7:0] rd_val;

  logic        ctrl_en;
  logic        ctrl_auto;
  logic        ctrl_irq_en;
  logic        expired;
  logic [15:0] reload;
  logic [15:0] count;
  logic [7:0]  count_hi_shadow;
  logic [7:0]  prescale;

  logic capture;
  logic wr_hit;
  logic wr_ctrl;
  logic wr_status;
  logic wr_reload_lo;
  logic wr_reload_hi;
  logic wr_prescale;
  logic rd_count_lo;
  logic tick;
  logic tick_eff;

  assign capture      = (state == BUS_IDLE) && req && cs;
  assign wr_hit       = capture && !rnw;
  assign wr_ctrl      = wr_hit && (addr == TMR_CTRL);
  assign wr_status    = wr_hit && (addr == TMR_STATUS);
  assign wr_reload_lo = wr_hit && (addr == TMR_RELOAD_LO);
  assign wr_reload_hi = wr_hit && (addr == TMR_RELOAD_HI);
  assign wr_prescale  = wr_hit && (addr == TMR_PRESCALE);
  assign rd_count_lo  = capture && rnw && (addr == TMR_COUNT_LO);

  // A CTRL or RELOAD_HI write in the tick cycle overrides the whole tick.
  assign tick_eff = tick && !wr_ctrl && !wr_reload_hi;

  lsuc_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_en),
    .clr   (wr_reload_hi),
    .div   (prescale),
    .tick  (tick)
  );

  always_comb begin
    rd_val = 8'h00;
    if (rnw) begin
      case (addr)
        TMR_CTRL:      rd_val = {5'b0, ctrl_irq_en, ctrl_auto, ctrl_en};
        TMR_STATUS:    rd_val = {7'b0, expired};
        TMR_RELOAD_LO: rd_val = reload[7:0];
        TMR_RELOAD_HI: rd_val = reload[15:8];
        TMR_COUNT_LO:  rd_val = count[7:0];
        TMR_COUNT_HI:  rd_val = count_hi_shadow;
        TMR_PRESCALE:  rd_val = prescale;
        default:       rd_val = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en         <= 1'b0;
      ctrl_auto       <= 1'b0;
      ctrl_irq_en     <= 1'b0;
      expired         <= 1'b0;
      reload          <= 16'h0000;
      count           <= 16'h0000;
      count_hi_shadow <= 8'h00;
      prescale        <= 8'h00;
      irq             <= 1'b0;
    end else begin
      // Clear first so a same-cycle expiry below keeps expired set.
      if (wr_status && wr_data[0]) begin
        expired <= 1'b0;
      end
      if (tick_eff) begin
        if (count != 16'h0000) begin
          count <= count - 16'h0001;
        end else begin
          expired <= 1'b1;
          if (ctrl_auto) begin
            count <= reload;
          end else begin
            ctrl_en <= 1'b0;
          end
        end
      end
      if (wr_ctrl) begin
        ctrl_en     <= wr_data[CTRL_EN_BIT];
        ctrl_auto   <= wr_data[CTRL_AUTO_RELOAD_BIT];
        ctrl_irq_en <= wr_data[CTRL_IRQ_EN_BIT];
      end
      if (wr_reload_lo) begin
        reload[7:0] <= wr_data;
      end
      if (wr_reload_hi) begin
        reload[15:8] <= wr_data;
        count        <= {wr_data, reload[7:0]};
      end
      if (wr_prescale) begin
        prescale <= wr_data;
      end
      // High byte is frozen on the low-byte read so a 16-bit read is coherent.
      if (rd_count_lo) begin
        count_hi_shadow <= count[15:8];
      end
      irq <= expired & ctrl_irq_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BUS_IDLE;
      wait_cnt <= 4'd0;
      rd_hold  <= 8'h00;
      rd_data  <= 8'h00;
      rdy      <= 1'b0;
    end else begin
      case (state)
        BUS_IDLE: begin
          rdy <= 1'b0;
          if (capture) begin
            if (WAIT_STATES == 4'd0) begin
              state   <= BUS_ACK;
              rdy     <= 1'b1;
              rd_data <= rd_val;
            end else begin
              state    <= BUS_WAIT;
              wait_cnt <= WAIT_STATES - 4'd1;
              rd_hold  <= rd_val;
            end
          end
        end
        BUS_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state   <= BUS_ACK;
            rdy     <= 1'b1;
            rd_data <= rd_hold;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        BUS_ACK: begin
          rdy   <= 1'b0;
          state <= BUS_IDLE;
        end
        default: begin
          rdy   <= 1'b0;
          state <= BUS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsuc_timer.sv
module tb_lsuc_timer;
  import lsuc_pkg::*;

  localparam int WS = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr;
  logic       rnw;
  logic       req;
  logic       req0;
  logic [7:0] wr_data;
  logic       cs;
  logic [7:0] rd_data, rd_data0;
  logic       rdy, rdy0;
  logic       irq, irq0;

  lsuc_timer #(.WAIT_STATES(4'd1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .rnw(rnw), .req(req),
    .wr_data(wr_data), .cs(cs), .rd_data(rd_data), .rdy(rdy), .irq(irq)
  );

  lsuc_timer #(.WAIT_STATES(4'd0)) dut0 (
    .clk(clk), .reset(reset), .addr(addr), .rnw(rnw), .req(req0),
    .wr_data(wr_data), .cs(cs), .rd_data(rd_data0), .rdy(rdy0), .irq(irq0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       chk;
    logic [7:0] data;
    int         req_cyc;
    string      name;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy_cnt = 0;
  int   rdy0_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors: one pop per rdy pulse.
  always @(negedge clk) begin
    if (rdy === 1'b1) begin
      exp_t e;
      rdy_cnt++;
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rdy: rdy high with no access pending (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        check({e.name, "_latency"}, cyc - e.req_cyc, WS + 1);
        if (e.chk) check(e.name, int'(rd_data), int'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (rdy0 === 1'b1) begin
      exp_t e;
      rdy0_cnt++;
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rdy0: rdy high with no access pending (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        check({e.name, "_latency"}, cyc - e.req_cyc, 1);
        if (e.chk) check(e.name, int'(rd_data0), int'(e.data));
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic r, input logic [7:0] wd,
                      input logic [7:0] exp, input string nm, input bit push);
    exp_t e;
    @(negedge clk);
    addr = a; rnw = r; wr_data = wd; req = 1'b1;
    if (push) begin
      e.chk = r; e.data = exp; e.req_cyc = cyc; e.name = nm;
      q1.push_back(e);
    end
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    send(a, 1'b0, d, 8'h00, "wr", 1'b1);
    repeat (WS + 1) @(posedge clk);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
    send(a, 1'b1, 8'h00, exp, nm, 1'b1);
    repeat (WS + 1) @(posedge clk);
  endtask

  task automatic access0(input logic [7:0] a, input logic r, input logic [7:0] wd,
                         input logic [7:0] exp, input string nm);
    exp_t e;
    @(negedge clk);
    addr = a; rnw = r; wr_data = wd; req0 = 1'b1;
    e.chk = r; e.data = exp; e.req_cyc = cyc; e.name = nm;
    q0.push_back(e);
    @(posedge clk);
    #1 req0 = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    reset = 1'b1; req = 1'b0; req0 = 1'b0; cs = 1'b1;
    addr = 8'h00; rnw = 1'b1; wr_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Reset state
    check("rst_rdy", int'(rdy), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_irq", int'(irq), 0);
    rd(TMR_CTRL, 8'h00, "rst_ctrl");
    rd(TMR_COUNT_LO, 8'h00, "rst_count_lo");
    check("rst_irq_after_reads", int'(irq), 0);

    // Auto-reload with interrupt: reload 3, tick every 2 clocks
    wr(TMR_RELOAD_LO, 8'h03);
    wr(TMR_RELOAD_HI, 8'h00);
    wr(TMR_PRESCALE, 8'h01);
    rd(TMR_RELOAD_LO, 8'h03, "reload_lo");
    rd(TMR_PRESCALE, 8'h01, "prescale");
    rd(TMR_COUNT_LO, 8'h03, "count_loaded");
    send(TMR_CTRL, 1'b0, 8'h07, 8'h00, "wr_ctrl", 1'b1);   // req in cycle 0
    repeat (7) @(posedge clk);
    @(negedge clk);                                         // cycle 8
    check("irq_before_expiry", int'(irq), 0);
    send(TMR_COUNT_LO, 1'b1, 8'h00, 8'h03, "count_reloaded", 1'b1); // cycle 9
    @(negedge clk);                                         // cycle 10
    check("irq_at_expiry", int'(irq), 1);
    @(negedge clk);                                         // cycle 11
    send(TMR_STATUS, 1'b0, 8'h01, 8'h00, "wr_status", 1'b1); // cycle 12
    @(negedge clk);                                         // cycle 13
    @(negedge clk);                                         // cycle 14
    check("irq_after_clear", int'(irq), 0);
    wr(TMR_CTRL, 8'h00);                                    // cycle 15
    rd(TMR_STATUS, 8'h00, "status_cleared");
    rd(TMR_COUNT_LO, 8'h00, "count_stopped");

    // One-shot: reload 2, prescale 0
    wr(TMR_PRESCALE, 8'h00);
    wr(TMR_RELOAD_LO, 8'h02);
    wr(TMR_RELOAD_HI, 8'h00);
    wr(TMR_CTRL, 8'h01);
    repeat (4) @(posedge clk);
    rd(TMR_CTRL, 8'h00, "oneshot_ctrl");
    rd(TMR_COUNT_LO, 8'h00, "oneshot_count_lo");
    rd(TMR_COUNT_HI, 8'h00, "oneshot_count_hi");
    rd(TMR_STATUS, 8'h01, "oneshot_expired");
    check("oneshot_irq", int'(irq), 0);
    wr(TMR_STATUS, 8'h00);
    rd(TMR_STATUS, 8'h01, "status_write0_noeffect");
    wr(TMR_STATUS, 8'h01);
    rd(TMR_STATUS, 8'h00, "status_write1_clears");

    // Torn-read guard: count passes 0x0100 at the COUNT_LO capture
    wr(TMR_RELOAD_LO, 8'h02);
    wr(TMR_RELOAD_HI, 8'h01);
    wr(TMR_CTRL, 8'h01);
    rd(TMR_COUNT_LO, 8'h00, "torn_lo");
    rd(TMR_COUNT_HI, 8'h01, "torn_hi");
    rd(TMR_COUNT_LO, 8'hFA, "count_running");
    wr(TMR_CTRL, 8'h00);

    // Unmapped offsets and aliases
    wr(TMR_PRESCALE, 8'h33);
    rd(8'h07, 8'h00, "unmapped_07");
    rd(8'h40, 8'h00, "unmapped_40");
    wr(8'h40, 8'hFF);
    wr(8'h46, 8'hFF);
    rd(TMR_CTRL, 8'h00, "ctrl_after_unmapped");
    rd(TMR_PRESCALE, 8'h33, "prescale_after_unmapped");

    // req without cs
    r = rdy_cnt;
    @(negedge clk);
    cs = 1'b0; addr = TMR_CTRL; rnw = 1'b0; wr_data = 8'h07; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0; cs = 1'b1;
    repeat (4) @(posedge clk);
    check("no_rdy_without_cs", rdy_cnt, r);
    rd(TMR_CTRL, 8'h00, "ctrl_after_nocs");

    // req during WAIT is ignored
    send(TMR_STATUS, 1'b1, 8'h00, 8'h00, "status_rd", 1'b1);
    addr = TMR_CTRL; rnw = 1'b0; wr_data = 8'h07; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (2) @(posedge clk);
    rd(TMR_CTRL, 8'h00, "req_in_wait_ignored");

    // Reset during WAIT of a CTRL write
    r = rdy_cnt;
    send(TMR_CTRL, 1'b0, 8'h05, 8'h00, "aborted", 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    check("no_rdy_after_reset", rdy_cnt, r);
    rd(TMR_CTRL, 8'h00, "ctrl_after_reset");

    // Zero wait states
    access0(TMR_PRESCALE, 1'b0, 8'h5A, 8'h00, "ws0_wr");
    access0(TMR_PRESCALE, 1'b1, 8'h00, 8'h5A, "ws0_prescale");
    access0(TMR_CTRL, 1'b1, 8'h00, 8'h00, "ws0_ctrl");

    repeat (5) @(posedge clk);
    check("pending_accesses", q1.size(), 0);
    check("pending_accesses_ws0", q0.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
